data_memory_io: RTL



---
 rtl/data_memory_io.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_io.sv
// Memory-mapped I/O register block sitting beside the data memory.
// Provides LEDR, HEX display data/blanking, synchronized switches, debounced
// keys with rising-edge capture, and a 1-cycle registered read port.
module data_memory_io #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic [9:0]  address,
  input  logic [3:0]  byteena,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  input  logic [13:0] io_input_bus,
  output logic [51:0] io_output_bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Active-low gfedcba segment pattern for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [9:0]       ledr_q, ledr_d;
  logic [23:0]      hex_data_q, hex_data_d;
  logic [5:0]       hex_blank_q, hex_blank_d;
  logic [9:0]       sw_meta_q, sw_sync_q;
  logic [3:0]       key_meta_q, key_sync_q;
  logic [3:0]       level_q, level_d;
  logic [3:0]       armed_q, armed_d;
  logic [3:0]       key_edge_q, key_edge_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [31:0]      rdata;

  logic        wr;
  logic [2:0]  reg_sel;
  logic [23:0] wmask;
  logic [3:0]  sample;
  logic [3:0]  edge_clr;
  logic        unused_bits;

  assign wr          = wren & sel;
  assign reg_sel     = address[2:0];
  assign wmask       = {{8{byteena[2]}}, {8{byteena[1]}}, {8{byteena[0]}}};
  assign sample      = ~key_sync_q;  // 1 = pressed
  assign edge_clr    = (wr && reg_sel == 3'd5 && byteena[0]) ? data[3:0] : 4'h0;
  assign unused_bits = ^{address[9:3], byteena[3], data[31:24]};

  // Byte-lane masked updates of the writable control registers.
  always_comb begin
    ledr_d      = ledr_q;
    hex_data_d  = hex_data_q;
    hex_blank_d = hex_blank_q;
    if (wr) begin
      unique case (reg_sel)
        3'd0: ledr_d = (ledr_q & ~wmask[9:0]) | (data[9:0] & wmask[9:0]);
        3'd1: hex_data_d = (hex_data_q & ~wmask) | (data[23:0] & wmask);
        3'd2: hex_blank_d = (hex_blank_q & ~wmask[5:0]) | (data[5:0] & wmask[5:0]);
        default: ;
      endcase
    end
  end

  // Per-key debounce. After reset a key is disarmed and must first be seen
  // released for a full debounce period, so a key held through reset never
  // produces a press until it is released and pressed again.
  always_comb begin
    level_d = level_q;
    armed_d = armed_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (!armed_q[i]) begin
        if (!sample[i]) begin
          if (cnt_q[i] == CntMax) armed_d[i] = 1'b1;
          else                    cnt_d[i]   = cnt_q[i] + 1'b1;
        end
      end else if (sample[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) level_d[i] = ~level_q[i];
        else                    cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edge capture: a new press sets the bit and wins over a same-cycle W1C.
  always_comb begin
    key_edge_d = (key_edge_q & ~edge_clr) | (level_d & ~level_q);
  end

  // Read mux, sampled into q on every edge regardless of sel/wren.
  always_comb begin
    rdata = 32'h0;
    unique case (reg_sel)
      3'd0: rdata = {22'h0, ledr_q};
      3'd1: rdata = {8'h0, hex_data_q};
      3'd2: rdata = {26'h0, hex_blank_q};
      3'd3: rdata = {22'h0, sw_sync_q};
      3'd4: rdata = {28'h0, level_q};
      3'd5: rdata = {28'h0, key_edge_q};
      default: rdata = 32'h0;
    endcase
  end

  // Board outputs are combinational from the registers.
  always_comb begin
    io_output_bus[9:0] = ledr_q;
    for (int n = 0; n < 6; n++) begin
      io_output_bus[10 + 7*n +: 7] = hex_blank_q[n] ? 7'h7F : seg7(hex_data_q[4*n +: 4]);
    end
  end

  // State registers, synchronizers and read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ledr_q      <= '0;
      hex_data_q  <= '0;
      hex_blank_q <= 6'h3F;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      key_meta_q  <= '1;
      key_sync_q  <= '1;
      level_q     <= '0;
      armed_q     <= '0;
      key_edge_q  <= '0;
      q           <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      ledr_q      <= ledr_d;
      hex_data_q  <= hex_data_d;
      hex_blank_q <= hex_blank_d;
      sw_meta_q   <= io_input_bus[9:0];
      sw_sync_q   <= sw_meta_q;
      key_meta_q  <= io_input_bus[13:10];
      key_sync_q  <= key_meta_q;
      level_q     <= level_d;
      armed_q     <= armed_d;
      key_edge_q  <= key_edge_d;
      q           <= rdata;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
